// File: rtl/calc_cmd_ctrl_if.sv
// Pin-side bundle of the calculator command controller: command request,
// key input and transmitter handshake in, datapath control strobes out.
interface calc_cmd_ctrl_if;
    logic       input_key;
    logic       valid_cmd;
    logic       rw_mem;
    logic [7:0] addr;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic [3:0] sel;
    logic       tx_done;

    logic       calc_active;
    logic       calc_mode;
    logic       busy;
    logic       cmd_ack;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic [3:0] alu_sel;
    logic       alu_en;
    logic [7:0] mem_addr;
    logic       access_mem;
    logic       mem_rw;
    logic       tx_start;
    logic       tx_timeout;

    modport master (
        output input_key, valid_cmd, rw_mem, addr, in_a, in_b, sel, tx_done,
        input  calc_active, calc_mode, busy, cmd_ack, op_a, op_b, alu_sel,
               alu_en, mem_addr, access_mem, mem_rw, tx_start, tx_timeout
    );

    modport slave (
        input  input_key, valid_cmd, rw_mem, addr, in_a, in_b, sel, tx_done,
        output calc_active, calc_mode, busy, cmd_ack, op_a, op_b, alu_sel,
               alu_en, mem_addr, access_mem, mem_rw, tx_start, tx_timeout
    );
endinterface

// File: rtl/calc_cmd_ctrl.sv
// Calculator command controller: serial key unlock plus command sequencing FSM.
// Optional TX_WAIT watchdog is enabled with `define CALC_CTRL_TXTIMEOUT_EN.
module calc_cmd_ctrl #(
    parameter int unsigned TX_TIMEOUT = 255
) (
    input  logic           clk,
    input  logic           reset,
    calc_cmd_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_EXEC     = 3'd1,
        ST_MEM_WR   = 3'd2,
        ST_MEM_RD   = 3'd3,
        ST_TX_START = 3'd4,
        ST_TX_WAIT  = 3'd5
    } state_t;

    if ((TX_TIMEOUT < 1) || (TX_TIMEOUT > 65535)) begin : g_bad_timeout
        $error("TX_TIMEOUT must be within 1..65535");
    end

    state_t     state_r, state_nx_s;
    logic       accept_s;
    logic       cmd_mem_r;
    logic [2:0] key_hist_r;
    logic [3:0] key_win_s;
    logic       key_dir_s, key_mem_s;
    logic       calc_active_r, calc_mode_r, busy_r, cmd_ack_r;
    logic       alu_en_r, access_mem_r, mem_rw_r, tx_start_r;
    logic [7:0] op_a_r, op_b_r, mem_addr_r;
    logic [3:0] alu_sel_r;

`ifdef CALC_CTRL_TXTIMEOUT_EN
    logic [15:0] to_cnt_r;
    logic        timeout_hit_s;
    logic        tx_timeout_r;
    localparam logic [15:0] TO_LAST = 16'(TX_TIMEOUT - 32'd1);
`endif

    // The 4-bit key window is the three previous bits plus the bit being sampled now
    always_comb begin
        key_win_s = {key_hist_r, bus.input_key};
        key_dir_s = (key_win_s == 4'b1010);
        key_mem_s = (key_win_s == 4'b1011);
    end

    // Next-state decode; the command kind is latched so a mode change cannot redirect it
    always_comb begin
        state_nx_s = state_r;
        accept_s   = 1'b0;
`ifdef CALC_CTRL_TXTIMEOUT_EN
        timeout_hit_s = 1'b0;
`endif
        case (state_r)
            ST_IDLE: begin
                if (calc_active_r && bus.valid_cmd) begin
                    accept_s = 1'b1;
                    if (calc_mode_r && !bus.rw_mem) begin
                        state_nx_s = ST_MEM_RD;
                    end else begin
                        state_nx_s = ST_EXEC;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (cmd_mem_r) begin
                    state_nx_s = ST_MEM_WR;
                end else begin
                    state_nx_s = ST_TX_START;
                end
            end
            ST_MEM_WR:   state_nx_s = ST_IDLE;
            ST_MEM_RD:   state_nx_s = ST_TX_START;
            ST_TX_START: state_nx_s = ST_TX_WAIT;
            ST_TX_WAIT: begin
                if (bus.tx_done) begin
                    state_nx_s = ST_IDLE;
`ifdef CALC_CTRL_TXTIMEOUT_EN
                end else if (to_cnt_r == TO_LAST) begin
                    state_nx_s    = ST_IDLE;
                    timeout_hit_s = 1'b1;
`endif
                end else begin
                    state_nx_s = ST_TX_WAIT;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Key detector; activation picks the mode, deactivation keeps it
    always_ff @(posedge clk) begin
        if (reset) begin
            key_hist_r    <= 3'b000;
            calc_active_r <= 1'b0;
            calc_mode_r   <= 1'b0;
        end else if (key_dir_s || key_mem_s) begin
            key_hist_r <= 3'b000;
            if (calc_active_r) begin
                calc_active_r <= 1'b0;
            end else begin
                calc_active_r <= 1'b1;
                calc_mode_r   <= key_mem_s;
            end
        end else begin
            key_hist_r <= key_win_s[2:0];
        end
    end

    // State register, registered strobes decoded from the next state, operand latches
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            cmd_mem_r    <= 1'b0;
            busy_r       <= 1'b0;
            cmd_ack_r    <= 1'b0;
            alu_en_r     <= 1'b0;
            access_mem_r <= 1'b0;
            mem_rw_r     <= 1'b0;
            tx_start_r   <= 1'b0;
            op_a_r       <= 8'h00;
            op_b_r       <= 8'h00;
            alu_sel_r    <= 4'h0;
            mem_addr_r   <= 8'h00;
        end else begin
            state_r      <= state_nx_s;
            busy_r       <= (state_nx_s != ST_IDLE);
            cmd_ack_r    <= accept_s;
            alu_en_r     <= (state_nx_s == ST_EXEC);
            access_mem_r <= (state_nx_s == ST_MEM_WR) || (state_nx_s == ST_MEM_RD);
            mem_rw_r     <= (state_nx_s == ST_MEM_WR);
            tx_start_r   <= (state_nx_s == ST_TX_START);
            if (accept_s) begin
                cmd_mem_r  <= calc_mode_r;
                op_a_r     <= bus.in_a;
                op_b_r     <= bus.in_b;
                alu_sel_r  <= bus.sel;
                mem_addr_r <= bus.addr;
            end
        end
    end

`ifdef CALC_CTRL_TXTIMEOUT_EN
    // Watchdog: counts TX_WAIT cycles; flag is sticky until the next accepted command
    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt_r     <= 16'h0000;
            tx_timeout_r <= 1'b0;
        end else begin
            if (state_r == ST_TX_WAIT) begin
                to_cnt_r <= to_cnt_r + 16'h0001;
            end else begin
                to_cnt_r <= 16'h0000;
            end
            if (accept_s) begin
                tx_timeout_r <= 1'b0;
            end else if (timeout_hit_s) begin
                tx_timeout_r <= 1'b1;
            end
        end
    end
    assign bus.tx_timeout = tx_timeout_r;
`else
    assign bus.tx_timeout = 1'b0;
`endif

    assign bus.calc_active = calc_active_r;
    assign bus.calc_mode   = calc_mode_r;
    assign bus.busy        = busy_r;
    assign bus.cmd_ack     = cmd_ack_r;
    assign bus.op_a        = op_a_r;
    assign bus.op_b        = op_b_r;
    assign bus.alu_sel     = alu_sel_r;
    assign bus.alu_en      = alu_en_r;
    assign bus.mem_addr    = mem_addr_r;
    assign bus.access_mem  = access_mem_r;
    assign bus.mem_rw      = mem_rw_r;
    assign bus.tx_start    = tx_start_r;
endmodule

// File: tb/tb_calc_cmd_ctrl.sv
// Directed bench for calc_cmd_ctrl: cycle table for unlock and a direct command,
// then hand-written sequences for memory mode, held requests, resets and the watchdog.
module tb_calc_cmd_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    calc_cmd_ctrl_if bus ();

    calc_cmd_ctrl #(.TX_TIMEOUT(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       key;
        logic       vc;
        logic       done;
        logic [7:0] a;
        logic [7:0] exp_out;   // {active, mode, busy, ack, alu_en, access, mem_rw, tx_start}
        logic [7:0] exp_opa;
    } vec_t;

    vec_t vecs[14];

    function automatic logic [7:0] outs();
        return {bus.calc_active, bus.calc_mode, bus.busy, bus.cmd_ack,
                bus.alu_en, bus.access_mem, bus.mem_rw, bus.tx_start};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_key(input logic [3:0] pat);
        for (int i = 3; i >= 0; i--) begin
            bus.input_key = pat[i];
            tick();
        end
        bus.input_key = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        // ---- unlock + direct command, one row per clock (row 4 = acceptance edge) ----
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h80, 8'h00};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 8'h55, 8'hB8, 8'h55};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 8'hFF, 8'hA1, 8'h55};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 8'hFF, 8'hA0, 8'h55};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 8'hFF, 8'hA0, 8'h55};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 8'hFF, 8'hA0, 8'h55};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 8'hFF, 8'h80, 8'h55};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 8'hFF, 8'h80, 8'h55};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 8'hFF, 8'h80, 8'h55};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 8'hFF, 8'h80, 8'h55};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 8'hFF, 8'h00, 8'h55};

        reset = 1'b1;
        bus.input_key = 1'b1; bus.valid_cmd = 1'b1; bus.rw_mem = 1'b1;
        bus.addr = 8'hEE; bus.in_a = 8'hAA; bus.in_b = 8'hBB; bus.sel = 4'hC;
        bus.tx_done = 1'b0;
        tick(); tick();
        chk("reset_outs", {24'h0, outs()}, 32'h0);
        chk("reset_ops", {bus.op_a, bus.op_b, bus.mem_addr, 4'h0, bus.alu_sel}, 32'h0);
        chk("reset_timeout", {31'h0, bus.tx_timeout}, 32'h0);
        reset = 1'b0;
        bus.input_key = 1'b0; bus.valid_cmd = 1'b0; bus.rw_mem = 1'b0;
        bus.addr = 8'h00; bus.in_b = 8'h2A; bus.sel = 4'h1;

        for (int i = 0; i < 14; i++) begin
            bus.input_key = vecs[i].key;
            bus.valid_cmd = vecs[i].vc;
            bus.tx_done   = vecs[i].done;
            bus.in_a      = vecs[i].a;
            tick();
            chk($sformatf("vec%0d_outs", i), {24'h0, outs()}, {24'h0, vecs[i].exp_out});
            chk($sformatf("vec%0d_opa", i), {24'h0, bus.op_a}, {24'h0, vecs[i].exp_opa});
        end
        bus.tx_done = 1'b0;
        chk("direct_opb", {24'h0, bus.op_b}, 32'h2A);
        chk("direct_sel", {28'h0, bus.alu_sel}, 32'h1);

        // ---- memory mode: write then read ----
        send_key(4'b1011);
        chk("mem_unlock", {30'h0, bus.calc_active, bus.calc_mode}, 32'h3);
        bus.valid_cmd = 1'b1; bus.rw_mem = 1'b1; bus.addr = 8'h10; bus.in_a = 8'h03;
        tick();
        bus.valid_cmd = 1'b0;
        chk("memwr_c1", {24'h0, outs()}, 32'hF8);
        tick();
        chk("memwr_c2", {24'h0, outs()}, 32'hE6);
        chk("memwr_addr", {24'h0, bus.mem_addr}, 32'h10);
        tick();
        chk("memwr_c3", {24'h0, outs()}, 32'hC0);
        bus.valid_cmd = 1'b1; bus.rw_mem = 1'b0; bus.addr = 8'h20;
        tick();
        bus.valid_cmd = 1'b0;
        chk("memrd_c1", {24'h0, outs()}, 32'hF4);
        chk("memrd_addr", {24'h0, bus.mem_addr}, 32'h20);
        tick();
        chk("memrd_c2", {24'h0, outs()}, 32'hE1);
        tick();
        chk("memrd_c3", {24'h0, outs()}, 32'hE0);
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        chk("memrd_idle", {24'h0, outs()}, 32'hC0);

        // ---- back to direct mode, ValidCmd held high ----
        send_key(4'b1010);
        chk("deact_mode_held", {30'h0, bus.calc_active, bus.calc_mode}, 32'h1);
        send_key(4'b1010);
        chk("direct_reunlock", {30'h0, bus.calc_active, bus.calc_mode}, 32'h2);
        bus.valid_cmd = 1'b1; bus.in_a = 8'h11;
        tick();
        chk("held_ack1", {24'h0, outs()}, 32'hB8);
        bus.in_a = 8'h22;
        tick();
        chk("held_c2", {24'h0, outs()}, 32'hA1);
        chk("held_opa_stable", {24'h0, bus.op_a}, 32'h11);
        tick();
        chk("held_c3", {24'h0, outs()}, 32'hA0);
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        chk("held_c4_idle", {24'h0, outs()}, 32'h80);
        tick();
        chk("held_ack2", {24'h0, outs()}, 32'hB8);
        chk("held_opa2", {24'h0, bus.op_a}, 32'h22);
        bus.valid_cmd = 1'b0;
        tick();
        chk("held_c2b", {24'h0, outs()}, 32'hA1);

        // ---- deactivate while busy: command completes, no new acceptance ----
        send_key(4'b1010);
        chk("deact_busy", {24'h0, outs()}, 32'h20);
        bus.valid_cmd = 1'b1; bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        chk("deact_idle", {24'h0, outs()}, 32'h00);
        tick();
        chk("deact_no_accept", {24'h0, outs()}, 32'h00);
        bus.valid_cmd = 1'b0;

        // ---- reset while in TX_WAIT ----
        send_key(4'b1010);
        bus.valid_cmd = 1'b1; bus.in_a = 8'h77; bus.addr = 8'h44;
        tick();
        bus.valid_cmd = 1'b0;
        tick(); tick();
        chk("pre_reset_wait", {24'h0, outs()}, 32'hA0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_mid_outs", {24'h0, outs()}, 32'h00);
        chk("rst_mid_ops", {bus.op_a, bus.mem_addr}, 32'h0);
        bus.valid_cmd = 1'b1;
        tick(); tick();
        chk("rst_locked", {24'h0, outs()}, 32'h00);
        bus.valid_cmd = 1'b0;

        // ---- TX_WAIT watchdog ----
        send_key(4'b1010);
        bus.valid_cmd = 1'b1;
        tick();
        bus.valid_cmd = 1'b0;
        tick(); tick();
`ifdef CALC_CTRL_TXTIMEOUT_EN
        for (int c = 3; c < 10; c++) tick();
        chk("to_c10_busy", {30'h0, bus.busy, bus.tx_timeout}, 32'h2);
        tick();
        chk("to_c11_idle", {30'h0, bus.busy, bus.tx_timeout}, 32'h1);
        bus.valid_cmd = 1'b1;
        tick();
        bus.valid_cmd = 1'b0;
        chk("to_cleared", {30'h0, bus.cmd_ack, bus.tx_timeout}, 32'h2);
`else
        for (int c = 0; c < 20; c++) tick();
        chk("nowd_still_wait", {24'h0, outs()}, 32'hA0);
        chk("nowd_flag", {31'h0, bus.tx_timeout}, 32'h0);
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        chk("nowd_done", {24'h0, outs()}, 32'h80);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/calc_cmd_ctrl.md
# calc_cmd_ctrl

Command controller for the binary calculator. It unlocks the calculator through a serial key sequence on `InputKey`, then accepts `ValidCmd` requests. For each request it sequences the shared datapath: operand/select latching for the ALU, a single-cycle memory access, and the start/completion handshake with the serial transmitter. It sits between the top-level pins and the ALU, memory and transmitter blocks, and is the only source of their control strobes.

## Interface
- `TX_TIMEOUT`, default 255: TX_WAIT watchdog limit in cycles. Used only with `CALC_CTRL_TXTIMEOUT_EN`; valid range 1..65535.
- `Clk` in 1: system clock; all logic is rising-edge.
- `Reset` in 1: synchronous, active-high reset.
- `InputKey` in 1: serial unlock key, sampled every cycle.
- `ValidCmd` in 1: command request, level-sampled.
- `RWMem` in 1: in memory mode, 1 = write ALU result, 0 = read.
- `Addr` in 8: memory address for the command.
- `InA`, `InB` in 8 each: ALU operands.
- `Sel` in 4: ALU operation select.
- `TxDone` in 1: transmitter finished the frame (pulse or level).
- `CalcActive` out 1: calculator unlocked.
- `CalcMode` out 1: 0 = direct (ALU→Tx), 1 = memory mode.
- `Busy` out 1: FSM not in IDLE.
- `CmdAck` out 1: one-cycle pulse when a command is accepted.
- `OpA`, `OpB` out 8; `AluSel` out 4: latched operands and select.
- `AluEn` out 1: ALU result-register load strobe.
- `MemAddr` out 8: latched address.
- `AccessMem` out 1; `RwMem` out 1: memory strobe and direction.
- `TxStart` out 1: transmitter start pulse; the transmitter samples its data on this cycle.
- `TxTimeout` out 1: sticky watchdog flag.

## Operation
- Key detector: a 4-bit shift register of `InputKey`, oldest bit first, runs in every state.
  - Pattern 1,0,1,0 while inactive: set CalcActive=1, CalcMode=0.
  - Pattern 1,0,1,1 while inactive: set CalcActive=1, CalcMode=1.
  - Either pattern while active: clear CalcActive; CalcMode is held.
  - The shift register clears after any match, so overlapping bits are not reused.
- Deactivation while Busy: CalcActive drops immediately. The in-flight command still completes; no new command is accepted.
- FSM states: IDLE, EXEC, MEM_WR, MEM_RD, TX_START, TX_WAIT.
- Acceptance: in IDLE, with CalcActive=1 and ValidCmd=1, latch InA/InB/Sel/Addr into OpA/OpB/AluSel/MemAddr and pulse CmdAck next cycle.
  - CalcMode=0: IDLE→EXEC→TX_START→TX_WAIT→IDLE.
  - CalcMode=1, RWMem=1: IDLE→EXEC→MEM_WR→IDLE.
  - CalcMode=1, RWMem=0: IDLE→MEM_RD→TX_START→TX_WAIT→IDLE.
- Output decode:
  - AluEn=1 only in EXEC.
  - AccessMem=1 in MEM_WR and MEM_RD.
  - RwMem=1 only in MEM_WR; 0 otherwise.
  - TxStart=1 only in TX_START.
- ValidCmd while Busy is ignored, not queued. A level held high re-issues the command after returning to IDLE.
- TX_WAIT exits on the cycle TxDone is sampled high. A TxDone seen in any other state is ignored.
- Operands stay latched until the next acceptance.

## Timing
- Reset values: all outputs 0; state IDLE; key shift register 0; latches 0; TxTimeout 0.
- Acceptance edge = cycle 0. From cycle 1:
  - CmdAck=1 and Busy=1 during cycle 1.
  - Direct command: AluEn in cycle 1, TxStart in cycle 2, TX_WAIT from cycle 3. A TxDone sampled at the end of cycle 3 gives IDLE in cycle 4.
  - Memory write: AluEn in cycle 1, AccessMem/RwMem in cycle 2, IDLE in cycle 3.
  - Memory read: AccessMem in cycle 1 (RwMem=0), TxStart in cycle 2, TX_WAIT from cycle 3.
- Unlock: CalcActive rises the cycle after the 4th key bit is sampled.
- Back-to-back: a new command is accepted on the first IDLE cycle, so the minimum direct spacing is 4 cycles.
- Reset asserted mid-command: the next edge restores all reset values. No partial strobe is emitted afterwards.

## Configuration
- `CALC_CTRL_TXTIMEOUT_EN` defined:
  - A 16-bit counter runs in TX_WAIT.
  - After TX_TIMEOUT cycles without TxDone, the FSM returns to IDLE and sets TxTimeout=1.
  - TxTimeout clears only on Reset or on the next CmdAck.
- Not defined: TX_WAIT waits indefinitely and TxTimeout is tied to 0.

## Test plan
- Reset, then InputKey 1,0,1,0 → CalcActive=1 and CalcMode=0 one cycle after the 4th bit; repeating the pattern → CalcActive=0.
- Direct mode, InA=8'h55, InB=8'h2A, Sel=4'h1, ValidCmd one cycle → CmdAck cycle 1, AluEn cycle 1, OpA=8'h55, TxStart cycle 2; TxDone at cycle 5 → IDLE cycle 6.
- Key 1,0,1,1, then RWMem=1, Addr=8'h10 → AluEn cycle 1, AccessMem=RwMem=1 cycle 2 with MemAddr=8'h10, Busy=0 cycle 3; then RWMem=0 → AccessMem=1/RwMem=0 cycle 1, TxStart cycle 2.
- ValidCmd held high through a direct command → second CmdAck exactly when the FSM re-enters IDLE+1; mid-command InA changes do not alter OpA.
- Reset in TX_WAIT → all outputs 0 next cycle; CalcActive=0; a subsequent ValidCmd is ignored until unlock.
- With `CALC_CTRL_TXTIMEOUT_EN` and TX_TIMEOUT=8, TxDone never asserted → IDLE and TxTimeout=1 after 8 TX_WAIT cycles; next CmdAck clears TxTimeout.
